// File: rtl/branch_predict_resolve_pkg.sv
// ============================================================================
// Package   : bju_pkg
// Purpose   : Shared constants, FSM type and counter helper for branch_predict_resolve.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package bju_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        FLUSHING = 1'b1
    } bju_state_e;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_resolve_if.sv
// ============================================================================
// Interface : branch_predict_resolve_if
// Purpose   : IF/EX pipeline connection of the branch resolution unit.
//             BJU_PERF_CNT_EN adds the performance counter outputs.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predict_resolve_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc_i;
    logic            if_pred_taken_o;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_branch_target_i;
    logic [XLEN-1:0] ex_jump_target_i;
    logic [2:0]      ex_function3_i;
    logic            ex_branch_i;
    logic            ex_jump_i;
    logic            ex_zero_i;
    logic            ex_sign_bit_i;
    logic            ex_sltu_bit_i;
    logic            ex_pred_taken_i;
    logic            stall_i;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_o;
`ifdef BJU_PERF_CNT_EN
    logic [31:0]     perf_branches_o;
    logic [31:0]     perf_mispredicts_o;

    modport master (
        output if_pc_i, ex_valid_i, ex_pc_i, ex_branch_target_i, ex_jump_target_i,
               ex_function3_i, ex_branch_i, ex_jump_i, ex_zero_i, ex_sign_bit_i,
               ex_sltu_bit_i, ex_pred_taken_i, stall_i,
        input  if_pred_taken_o, redirect_o, redirect_pc_o, flush_o,
               perf_branches_o, perf_mispredicts_o
    );
    modport slave (
        input  if_pc_i, ex_valid_i, ex_pc_i, ex_branch_target_i, ex_jump_target_i,
               ex_function3_i, ex_branch_i, ex_jump_i, ex_zero_i, ex_sign_bit_i,
               ex_sltu_bit_i, ex_pred_taken_i, stall_i,
        output if_pred_taken_o, redirect_o, redirect_pc_o, flush_o,
               perf_branches_o, perf_mispredicts_o
    );
`else
    modport master (
        output if_pc_i, ex_valid_i, ex_pc_i, ex_branch_target_i, ex_jump_target_i,
               ex_function3_i, ex_branch_i, ex_jump_i, ex_zero_i, ex_sign_bit_i,
               ex_sltu_bit_i, ex_pred_taken_i, stall_i,
        input  if_pred_taken_o, redirect_o, redirect_pc_o, flush_o
    );
    modport slave (
        input  if_pc_i, ex_valid_i, ex_pc_i, ex_branch_target_i, ex_jump_target_i,
               ex_function3_i, ex_branch_i, ex_jump_i, ex_zero_i, ex_sign_bit_i,
               ex_sltu_bit_i, ex_pred_taken_i, stall_i,
        output if_pred_taken_o, redirect_o, redirect_pc_o, flush_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/branch_predict_resolve_bht_2bit.sv
// ============================================================================
// Module    : bht_2bit
// Purpose   : Untagged array of 2-bit saturating counters, async read, sync update.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_2bit
    import bju_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  wire logic [$clog2(BHT_ENTRIES)-1:0] rd_idx_i,
    output logic      [1:0]                     rd_cnt_o,
    input  wire logic                           wr_en_i,
    input  wire logic [$clog2(BHT_ENTRIES)-1:0] wr_idx_i,
    input  wire logic                           wr_taken_i
);

    logic [1:0] cnt_q [BHT_ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= bht_next(cnt_q[wr_idx_i], wr_taken_i);
        end
    end

    // Read sees the pre-update value when it collides with a write.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/branch_predict_resolve.sv
// ============================================================================
// Module    : branch_predict_resolve
// Purpose   : EX-stage branch/jump resolution with bimodal BHT, redirect and flush.
//             Optional macro BJU_PERF_CNT_EN adds branch/mispredict counters.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_resolve
    import bju_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    branch_predict_resolve_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    bju_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             redirect_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             flush_q;

    logic             w_cond;
    logic             w_legal;
    logic             w_taken;
    logic             w_accept;
    logic             w_is_br;
    logic             w_mispred;
    logic             w_need;
    logic [XLEN-1:0]  w_target;
    logic [1:0]       w_rd_cnt;

    always_comb begin
        w_cond  = 1'b0;
        w_legal = 1'b1;
        case (bus.ex_function3_i)
            F3_BEQ:  w_cond = bus.ex_zero_i;
            F3_BNE:  w_cond = ~bus.ex_zero_i;
            F3_BLT:  w_cond = bus.ex_sign_bit_i;
            F3_BGE:  w_cond = ~bus.ex_sign_bit_i;
            F3_BLTU: w_cond = bus.ex_sltu_bit_i;
            F3_BGEU: w_cond = ~bus.ex_sltu_bit_i;
            default: w_legal = 1'b0;
        endcase
    end

    // A set jump bit overrides the branch bit, so "branch" means branch-only.
    assign w_is_br   = bus.ex_branch_i & ~bus.ex_jump_i;
    assign w_taken   = bus.ex_jump_i | (bus.ex_branch_i & w_legal & w_cond);
    assign w_accept  = bus.ex_valid_i & ~bus.stall_i & (state_q == IDLE);
    assign w_mispred = w_is_br & (w_taken != bus.ex_pred_taken_i);
    assign w_need    = w_accept & (bus.ex_jump_i | w_mispred);

    always_comb begin
        w_target = bus.ex_pc_i + XLEN'(4);
        if (bus.ex_jump_i) begin
            w_target = {bus.ex_jump_target_i[XLEN-1:1], 1'b0};
        end else if (w_taken) begin
            w_target = bus.ex_branch_target_i;
        end
    end

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (bus.if_pc_i[IDX_W+1:2]),
        .rd_cnt_o   (w_rd_cnt),
        .wr_en_i    (w_accept & w_is_br & w_legal),
        .wr_idx_i   (bus.ex_pc_i[IDX_W+1:2]),
        .wr_taken_i (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else if (!bus.stall_i) begin
            case (state_q)
                IDLE: begin
                    if (w_need) begin
                        state_q       <= FLUSHING;
                        cnt_q         <= CNT_W'(FLUSH_CYCLES);
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= w_target;
                        flush_q       <= 1'b1;
                    end else begin
                        redirect_q <= 1'b0;
                        flush_q    <= 1'b0;
                    end
                end
                FLUSHING: begin
                    redirect_q <= 1'b0;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_pred_taken_o = w_rd_cnt[1];
    assign bus.redirect_o      = redirect_q;
    assign bus.redirect_pc_o   = redirect_pc_q;
    assign bus.flush_o         = flush_q;

`ifdef BJU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (w_accept && w_is_br && (perf_br_q != '1)) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (w_accept && w_mispred && (perf_mp_q != '1)) begin
                perf_mp_q <= perf_mp_q + 32'd1;
            end
        end
    end

    assign bus.perf_branches_o    = perf_br_q;
    assign bus.perf_mispredicts_o = perf_mp_q;
`endif

endmodule

`default_nettype wire
